// File: rtl/wcu.sv
// Write channel unit: routes one AXI write transaction at a time from the granted
// master to one of two slaves chosen by address, tracking beats and end of transaction.
module wcu #(
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      SLV1_BASE  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            mas_sel,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  input  logic                  wvalid,
  input  logic                  wlast,
  input  logic                  bready,
  input  logic                  awready_s0,
  input  logic                  awready_s1,
  input  logic                  wready_s0,
  input  logic                  wready_s1,
  input  logic                  bvalid_s0,
  input  logic                  bvalid_s1,
  input  logic [1:0]            bresp_s0,
  input  logic [1:0]            bresp_s1,
  output logic                  awvalid_s0,
  output logic                  awvalid_s1,
  output logic                  wvalid_s0,
  output logic                  wvalid_s1,
  output logic                  bready_s0,
  output logic                  bready_s1,
  output logic                  awready,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  output logic [1:0]            slv_sel,
  output logic                  endtrans_1,
  output logic                  endtrans_2,
  output logic                  len_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_e;

  state_e     state_q;
  logic [1:0] owner_q;
  logic [1:0] slv_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;

  logic sel0, sel1;
  logic in_addr, in_data, in_resp, in_done;
  logic aw_hs, w_hs, b_hs;
  logic grant_ok;

  assign sel0    = (slv_q == 2'b01);
  assign sel1    = (slv_q == 2'b10);
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);
  assign in_done = (state_q == DONE);

  // Routing is gated by registered state and the latched slave select, so the
  // unselected slave and every inactive channel stay at zero.
  assign awvalid_s0 = in_addr & sel0 & awvalid;
  assign awvalid_s1 = in_addr & sel1 & awvalid;
  assign awready    = in_addr & ((sel0 & awready_s0) | (sel1 & awready_s1));

  assign wvalid_s0  = in_data & sel0 & wvalid;
  assign wvalid_s1  = in_data & sel1 & wvalid;
  assign wready     = in_data & ((sel0 & wready_s0) | (sel1 & wready_s1));

  assign bready_s0  = in_resp & sel0 & bready;
  assign bready_s1  = in_resp & sel1 & bready;
  assign bvalid     = in_resp & ((sel0 & bvalid_s0) | (sel1 & bvalid_s1));
  assign bresp      = !in_resp ? 2'b00 :
                      sel0     ? bresp_s0 :
                      sel1     ? bresp_s1 : 2'b00;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  assign grant_ok = (mas_sel == 2'b01) || (mas_sel == 2'b10);

  assign slv_sel    = slv_q;
  assign endtrans_1 = in_done & (owner_q == 2'b01);
  assign endtrans_2 = in_done & (owner_q == 2'b10);
  assign len_err    = w_hs & wlast & (cnt_q != len_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      slv_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_ok && awvalid) begin
            owner_q <= mas_sel;
            slv_q   <= (awaddr >= SLV1_BASE) ? 2'b10 : 2'b01;
            len_q   <= awlen;
            cnt_q   <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) state_q <= DATA;
        end
        DATA: begin
          if (w_hs) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            if (wlast) state_q <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            slv_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          owner_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wcu.sv
// Directed bench for wcu: drives master and slave sides at the falling edge and
// checks the full output vector shortly after.
module tb_wcu;

  logic        clk;
  logic        rstn;
  logic [1:0]  mas_sel;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, wvalid, wlast, bready;
  logic        awready_s0, awready_s1, wready_s0, wready_s1, bvalid_s0, bvalid_s1;
  logic [1:0]  bresp_s0, bresp_s1;
  logic        awvalid_s0, awvalid_s1, wvalid_s0, wvalid_s1, bready_s0, bready_s1;
  logic        awready, wready, bvalid;
  logic [1:0]  bresp, slv_sel;
  logic        endtrans_1, endtrans_2, len_err;
  logic [15:0] outs;

  int unsigned errors = 0;
  int unsigned checks = 0;

  wcu #(.ADDR_WIDTH(32), .SLV1_BASE(32'h8000_0000)) dut (
    .clk(clk), .rstn(rstn), .mas_sel(mas_sel), .awaddr(awaddr), .awlen(awlen),
    .awvalid(awvalid), .wvalid(wvalid), .wlast(wlast), .bready(bready),
    .awready_s0(awready_s0), .awready_s1(awready_s1),
    .wready_s0(wready_s0), .wready_s1(wready_s1),
    .bvalid_s0(bvalid_s0), .bvalid_s1(bvalid_s1),
    .bresp_s0(bresp_s0), .bresp_s1(bresp_s1),
    .awvalid_s0(awvalid_s0), .awvalid_s1(awvalid_s1),
    .wvalid_s0(wvalid_s0), .wvalid_s1(wvalid_s1),
    .bready_s0(bready_s0), .bready_s1(bready_s1),
    .awready(awready), .wready(wready), .bvalid(bvalid), .bresp(bresp),
    .slv_sel(slv_sel), .endtrans_1(endtrans_1), .endtrans_2(endtrans_2),
    .len_err(len_err)
  );

  assign outs = {awvalid_s0, awvalid_s1, wvalid_s0, wvalid_s1, bready_s0, bready_s1,
                 awready, wready, bvalid, bresp, slv_sel, endtrans_1, endtrans_2, len_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input logic aws0, aws1, ws0, ws1, bs0, bs1,
                                       input logic awr, wr, bv,
                                       input logic [1:0] br, sl,
                                       input logic e1, e2, le);
    return {aws0, aws1, ws0, ws1, bs0, bs1, awr, wr, bv, br, sl, e1, e2, le};
  endfunction

  task automatic clear_inputs();
    mas_sel = 2'b00; awaddr = '0; awlen = '0;
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
    awready_s0 = 0; awready_s1 = 0; wready_s0 = 0; wready_s1 = 0;
    bvalid_s0 = 0; bvalid_s1 = 0; bresp_s0 = 2'b00; bresp_s1 = 2'b00;
  endtask

  // One full write; sw flips mas_sel/awaddr mid-DATA, stall inserts refused beats with wlast.
  task automatic test_write(input logic [1:0] mas, input logic [31:0] addr,
                            input logic [7:0] len, input int unsigned nbeats,
                            input int unsigned stall, input logic [1:0] resp,
                            input logic sw, input string name);
    logic        s1;
    logic [1:0]  slv;
    logic [15:0] exp;
    logic        le;
    int unsigned cnt_before;
    s1  = (addr >= 32'h8000_0000);
    slv = s1 ? 2'b10 : 2'b01;

    @(negedge clk);
    mas_sel = mas; awaddr = addr; awlen = len; awvalid = 1;
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL %s_idle: got %h expected %h", name, outs, 16'h0000);
    end

    @(negedge clk);
    awready_s0 = !s1; awready_s1 = s1;
    #1 exp = pack(!s1, s1, 0, 0, 0, 0, 1, 0, 0, 2'b00, slv, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++; $display("FAIL %s_addr: got %h expected %h", name, outs, exp);
    end

    @(negedge clk);
    awvalid = 0; awready_s0 = 0; awready_s1 = 0;
    if (sw) begin
      mas_sel = 2'b10; awaddr = ~addr; awvalid = 1;
    end
    for (int unsigned i = 0; i < stall; i++) begin
      wvalid = 1; wlast = 1; wready_s0 = 0; wready_s1 = 0;
      #1 exp = pack(0, 0, !s1, s1, 0, 0, 0, 0, 0, 2'b00, slv, 0, 0, 0);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s_stall%0d: got %h expected %h", name, i, outs, exp);
      end
      @(negedge clk);
    end
    for (int unsigned b = 1; b <= nbeats; b++) begin
      wvalid = 1; wlast = (b == nbeats); wready_s0 = !s1; wready_s1 = s1;
      le = 1'b0;
      if (b == nbeats) begin
        cnt_before = (nbeats - 1 > 255) ? 255 : nbeats - 1;
        le = (cnt_before != int'(len));
      end
      #1 exp = pack(0, 0, !s1, s1, 0, 0, 0, 1, 0, 2'b00, slv, 0, 0, le);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL %s_beat%0d: got %h expected %h", name, b, outs, exp);
      end
      @(negedge clk);
    end

    wvalid = 0; wlast = 0; wready_s0 = 0; wready_s1 = 0; awvalid = 0;
    bvalid_s0 = !s1; bvalid_s1 = s1; bready = 1;
    bresp_s0 = s1 ? ~resp : resp;
    bresp_s1 = s1 ? resp : ~resp;
    #1 exp = pack(0, 0, 0, 0, !s1, s1, 0, 0, 1, resp, slv, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++; $display("FAIL %s_resp: got %h expected %h", name, outs, exp);
    end

    @(negedge clk);
    clear_inputs();
    #1 exp = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, mas == 2'b01, mas == 2'b10, 0);
    checks++;
    if (outs !== exp) begin
      errors++; $display("FAIL %s_done: got %h expected %h", name, outs, exp);
    end

    @(negedge clk);
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL %s_post: got %h expected %h", name, outs, 16'h0000);
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    mas_sel = 2'b01; awaddr = 32'h0000_1000; awlen = 8'd3;
    awvalid = 1; wvalid = 1; wlast = 1; bready = 1;
    awready_s0 = 1; awready_s1 = 1; wready_s0 = 1; wready_s1 = 1;
    bvalid_s0 = 1; bvalid_s1 = 1; bresp_s0 = 2'b11; bresp_s1 = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 checks++;
      if (outs !== 16'h0000) begin
        errors++; $display("FAIL reset%0d: got %h expected %h", i, outs, 16'h0000);
      end
    end
    @(negedge clk);
    clear_inputs();
    rstn = 1;
    @(negedge clk);
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL reset_rel: got %h expected %h", outs, 16'h0000);
    end
  endtask

  task automatic test_no_grant();
    logic [1:0] g;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 2'b11 : 2'b00;
      @(negedge clk);
      mas_sel = g; awaddr = 32'h0000_2000; awvalid = 1; awready_s0 = 1;
      @(negedge clk);
      #1 checks++;
      if (outs !== 16'h0000) begin
        errors++; $display("FAIL no_grant_%b: got %h expected %h", g, outs, 16'h0000);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    @(negedge clk);
    mas_sel = 2'b01; awaddr = 32'h9000_0000; awlen = 8'd0; awvalid = 1;
    @(negedge clk);
    awready_s1 = 1;
    @(negedge clk);
    awvalid = 0; awready_s1 = 0; mas_sel = 2'b00;
    wvalid = 1; wlast = 1; wready_s1 = 1;
    @(negedge clk);
    wvalid = 0; wlast = 0; wready_s1 = 0;
    bvalid_s1 = 1; bresp_s1 = 2'b10; bready = 1;
    #1 exp = pack(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0);
    checks++;
    if (outs !== exp) begin
      errors++; $display("FAIL rstmid_resp: got %h expected %h", outs, exp);
    end
    #1 rstn = 0;
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL rstmid_async: got %h expected %h", outs, 16'h0000);
    end
    @(negedge clk);
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL rstmid_hold: got %h expected %h", outs, 16'h0000);
    end
    clear_inputs();
    rstn = 1;
    @(negedge clk);
    #1 checks++;
    if (outs !== 16'h0000) begin
      errors++; $display("FAIL rstmid_rel: got %h expected %h", outs, 16'h0000);
    end
    test_write(2'b01, 32'h0000_0040, 8'd1, 2, 0, 2'b01, 1'b0, "rstmid_new");
  endtask

  task automatic test_basic_s0();
    test_write(2'b01, 32'h0000_1000, 8'd3, 4, 0, 2'b00, 1'b0, "basic_s0");
  endtask

  task automatic test_single_s1();
    test_write(2'b10, 32'h8000_0000, 8'd0, 1, 0, 2'b01, 1'b0, "single_s1");
  endtask

  task automatic test_decode_boundary();
    test_write(2'b10, 32'h7FFF_FFFF, 8'd1, 2, 0, 2'b11, 1'b0, "below_base");
  endtask

  task automatic test_len_err();
    test_write(2'b01, 32'h0000_3000, 8'd3, 2, 0, 2'b10, 1'b0, "len_short");
    test_write(2'b10, 32'hA000_0000, 8'd1, 3, 0, 2'b00, 1'b0, "len_long");
  endtask

  task automatic test_owner_latch();
    test_write(2'b01, 32'h0000_1000, 8'd2, 3, 0, 2'b00, 1'b1, "owner_latch");
  endtask

  task automatic test_wready_stall();
    test_write(2'b01, 32'h0000_0100, 8'd0, 1, 5, 2'b00, 1'b0, "stall");
  endtask

  task automatic test_saturation();
    test_write(2'b01, 32'h0000_2000, 8'd255, 257, 0, 2'b00, 1'b0, "sat");
  endtask

  initial begin
    clear_inputs();
    rstn = 0;
    test_reset();
    test_basic_s0();
    test_single_s1();
    test_decode_boundary();
    test_len_err();
    test_owner_latch();
    test_wready_stall();
    test_no_grant();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
